// File: rtl/kbd_pkg.sv
// Shared scan-code constants, decoder state encoding and direction helpers
// for the PS/2 arrow-key decoder.
package kbd_pkg;

    typedef enum logic [1:0] {IDLE_ST, EXT_ST, BRK_ST, EXT_BRK_ST} kbd_state_t;

    // Direction vector, MSB first: {up, down, left, right}
    typedef logic [3:0] dir_t;
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam logic [7:0] PFX_EXT  = 8'hE0;
    localparam logic [7:0] PFX_BRK  = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    // One-hot direction for an extended arrow code, zero for anything else
    function automatic dir_t arrow_dir(input logic [7:0] code);
        case (code)
            SC_UP:    arrow_dir = 4'b1000;
            SC_DOWN:  arrow_dir = 4'b0100;
            SC_LEFT:  arrow_dir = 4'b0010;
            SC_RIGHT: arrow_dir = 4'b0001;
            default:  arrow_dir = 4'b0000;
        endcase
    endfunction

    function automatic dir_t wasd_dir(input logic [7:0] code);
        case (code)
            SC_W:    wasd_dir = 4'b1000;
            SC_S:    wasd_dir = 4'b0100;
            SC_A:    wasd_dir = 4'b0010;
            SC_D:    wasd_dir = 4'b0001;
            default: wasd_dir = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/kbd_seq_timer.sv
// Saturating idle counter used to abandon a prefix sequence that never completed.
// expired is high while the count sits at TIMEOUT_CYCLES-1.
module kbd_seq_timer
#(
    parameter int TIMEOUT_CYCLES = 50000
)
(
    input  logic clk,
    input  logic resetN,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + CW'(1);
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/kbd_arrow_decoder.sv
// PS/2 scan-code stream -> held flags for up/down/left/right, with E0/F0 prefix
// tracking, repeat filtering and prefix timeout. Define KBD_WASD_EN to also map W/A/S/D.
module kbd_arrow_decoder
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
)
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       clear_all,
    output logic       up_key_pressed,
    output logic       down_key_pressed,
    output logic       left_key_pressed,
    output logic       right_key_pressed,
    output logic       key_event
);

    kbd_state_t state_q, state_d;
    dir_t       arrow_q, arrow_d;
    dir_t       dir_q, dir_d;
    dir_t       code_arrow;
    logic       key_event_q;
    logic       expired;
`ifdef KBD_WASD_EN
    dir_t       wasd_q, wasd_d;
    dir_t       code_wasd;
    assign code_wasd = wasd_dir(byte_data);
`endif

    assign code_arrow = arrow_dir(byte_data);

    kbd_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_seq_timer (
        .clk     (clk),
        .resetN  (resetN),
        .clr     (byte_valid || state_q == IDLE_ST),
        .en      (state_q != IDLE_ST),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        arrow_d = arrow_q;
`ifdef KBD_WASD_EN
        wasd_d  = wasd_q;
`endif
        if (clear_all) begin
            state_d = IDLE_ST;
            arrow_d = '0;
`ifdef KBD_WASD_EN
            wasd_d  = '0;
`endif
        end else if (byte_valid) begin
            // A byte always wins over a timeout expiring in the same cycle
            case (state_q)
                IDLE_ST: begin
                    if (byte_data == PFX_EXT)      state_d = EXT_ST;
                    else if (byte_data == PFX_BRK) state_d = BRK_ST;
                    else begin
`ifdef KBD_WASD_EN
                        wasd_d = wasd_q | code_wasd;
`endif
                        state_d = IDLE_ST;
                    end
                end
                EXT_ST: begin
                    if (byte_data == PFX_BRK)      state_d = EXT_BRK_ST;
                    else if (byte_data == PFX_EXT) state_d = EXT_ST;
                    else begin
                        arrow_d = arrow_q | code_arrow;
                        state_d = IDLE_ST;
                    end
                end
                BRK_ST: begin
                    if (byte_data == PFX_EXT) state_d = EXT_ST;
                    else begin
`ifdef KBD_WASD_EN
                        wasd_d = wasd_q & ~code_wasd;
`endif
                        state_d = IDLE_ST;
                    end
                end
                EXT_BRK_ST: begin
                    arrow_d = arrow_q & ~code_arrow;
                    state_d = IDLE_ST;
                end
                default: state_d = IDLE_ST;
            endcase
        end else if (expired) begin
            state_d = IDLE_ST;
        end
    end

`ifdef KBD_WASD_EN
    assign dir_d = arrow_d | wasd_d;
`else
    assign dir_d = arrow_d;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE_ST;
            arrow_q     <= '0;
            dir_q       <= '0;
            key_event_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arrow_q     <= arrow_d;
            dir_q       <= dir_d;
            key_event_q <= (dir_d != dir_q);
        end
    end

`ifdef KBD_WASD_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) wasd_q <= '0;
        else         wasd_q <= wasd_d;
    end
`endif

    assign up_key_pressed    = dir_q[DIR_UP];
    assign down_key_pressed  = dir_q[DIR_DOWN];
    assign left_key_pressed  = dir_q[DIR_LEFT];
    assign right_key_pressed = dir_q[DIR_RIGHT];
    assign key_event         = key_event_q;

endmodule
